// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and IR and prefetches the word at PC from ROM.
// Ports: clock/reset (async, active-low); pc_clr/pc_up/ld are controller requests;
// ir/ir_valid/fetch_busy/pc go to the controller; rom_addr/rom_rd/rom_data/rom_ack
// form the ROM handshake; state_o exposes the FSM state (FETCH=0, HOLD=1, DRAIN=2).
module instr_fetch_unit #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pc_clr,
  input  logic          pc_up,
  input  logic          ld,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  output logic          fetch_busy,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ack,
  output logic [1:0]    state_o
);
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nx;
  logic [DW-1:0] pf_buf;
  logic pf_valid, ld_pend, ack_ok, moved, take;
  logic [AW-1:0] pc_nx;
  always_comb begin
    ack_ok = rom_rd & rom_ack;
    moved = pc_clr | pc_up;
    pc_nx = pc_clr ? '0 : pc_up ? pc + AW'(1) : pc;
    // an ack seen in DRAIN belongs to a PC that has since moved on, so it is dropped
    state_nx = state == HOLD  ? (moved ? FETCH : HOLD) :
               state == DRAIN ? (ack_ok ? FETCH : DRAIN) :
               ack_ok ? (moved ? FETCH : HOLD) : (moved ? DRAIN : FETCH);
    // a pending (or same-cycle) ld is satisfied straight from the ROM data
    take = (state == FETCH) & ack_ok & (ld | ld_pend);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
      ir_valid <= 1'b0;
      rom_addr <= '0;
      rom_rd <= 1'b1;
      pf_buf <= '0;
      pf_valid <= 1'b0;
      ld_pend <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      rom_rd <= state_nx != HOLD;
      // a new request is launched only once the previous one is closed
      if (state_nx == FETCH && (state == HOLD || ack_ok)) rom_addr <= pc_nx;
      if (moved) pf_valid <= 1'b0;
      else if (state == FETCH && ack_ok) begin
        pf_buf <= rom_data;
        pf_valid <= 1'b1;
      end
      if (pc_clr) begin
        ir <= '0;
        ir_valid <= 1'b0;
        ld_pend <= 1'b0;
      end else if (take) begin
        ir <= rom_data;
        ir_valid <= 1'b1;
        ld_pend <= 1'b0;
      end else if (ld && pf_valid) begin
        ir <= pf_buf;
        ir_valid <= 1'b1;
      end else if (ld) ld_pend <= 1'b1;
    end
  end
  assign fetch_busy = ~pf_valid;
  assign state_o = state;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a latency-programmable ROM.
module tb_instr_fetch_unit;
  localparam int AW = 7;
  localparam int DW = 16;
  logic clock = 0, reset = 0, pc_clr = 0, pc_up = 0, ld = 0, rom_ack = 0;
  logic rom_rd, ir_valid, fetch_busy;
  logic [DW-1:0] ir, rom_data = '0;
  logic [AW-1:0] pc, rom_addr;
  logic [1:0] state_o;
  always #5 clock = ~clock;
  instr_fetch_unit #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset), .pc_clr(pc_clr), .pc_up(pc_up), .ld(ld),
    .ir(ir), .ir_valid(ir_valid), .fetch_busy(fetch_busy), .pc(pc),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .rom_ack(rom_ack),
    .state_o(state_o)
  );
  int checks = 0, errors = 0;
  logic [DW-1:0] rom [128];
  logic [DW-1:0] exp_q [$];
  int lat = 1;
  bit lat_rnd = 0;
  int mpc = 0;
  int busy_lds = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  logic active = 0;
  int cnt = 0;
  logic [AW-1:0] a = '0;
  always @(negedge clock) begin
    if (!reset) begin
      rom_ack = 0;
      active = 0;
    end else begin
      if (rom_ack) begin
        rom_ack = 0;
        active = 0;
      end
      if (active) begin
        chk("rom_req_stable", {rom_rd, rom_addr}, {1'b1, a});
        if (cnt <= 1) begin
          rom_ack = 1;
          rom_data = rom[a];
        end else cnt--;
      end else if (rom_rd) begin
        active = 1;
        a = rom_addr;
        cnt = lat_rnd ? int'($urandom_range(1, 4)) : lat;
      end
    end
  end
  logic [DW-1:0] last = '0;
  always @(negedge clock) begin
    if (!reset) last = '0;
    else if (ir !== last) begin
      if (ir_valid) begin
        if (exp_q.size() == 0) chk("ir_unexpected", exp_q.size(), 1);
        else chk("ir_seq", ir, exp_q.pop_front());
      end
      last = ir;
    end
  end
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    while (fetch_busy && n < 60) begin
      step();
      n++;
    end
    if (fetch_busy) chk(name, fetch_busy, 0);
  endtask
  task automatic fetch;
    exp_q.push_back(rom[mpc]);
    if (!fetch_busy) begin
      ld = 1;
      pc_up = 1;
      mpc = (mpc + 1) % 128;
      step();
      ld = 0;
      pc_up = 0;
    end else begin
      busy_lds++;
      ld = 1;
      step();
      ld = 0;
      wait_ready("ld_pend_timeout");
      pc_up = 1;
      mpc = (mpc + 1) % 128;
      step();
      pc_up = 0;
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] prog [9];
    logic [DW-1:0] hold_ir;
    int p, n;
    prog = '{16'h20A1, 16'h21A2, 16'h2033, 16'h28A4, 16'h4125, 16'h3536, 16'h4640, 16'h10BB, 16'h5000};
    for (int i = 0; i < 128; i++) rom[i] = {1'b1, 7'(i), 8'($urandom)};
    for (int i = 0; i < 9; i++) rom[i] = prog[i];
    step();
    step();
    reset = 1;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_rom_rd", rom_rd, 1);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_state", state_o, 0);
    chk("rst_busy", fetch_busy, 1);
    wait_ready("t1_first_fetch");
    chk("t1_state_hold", state_o, 1);
    fetch();
    chk("t1_ir", ir, 16'h20A1);
    chk("t1_ir_valid", ir_valid, 1);
    chk("t1_pc", pc, 1);
    chk("t1_rom_addr", rom_addr, 1);
    chk("t1_rom_rd", rom_rd, 1);
    repeat (8) begin
      repeat (3) step();
      chk("t2_busy_at_ld", fetch_busy, 0);
      fetch();
    end
    chk("t2_pc", pc, 9);
    step();
    step();
    chk("t2_drained", exp_q.size(), 0);
    lat = 3;
    wait_ready("t3_start");
    busy_lds = 0;
    repeat (30) fetch();
    chk("t3_busy_lds", busy_lds, 29);
    lat_rnd = 1;
    repeat (30) begin
      repeat ($urandom_range(0, 3)) step();
      fetch();
    end
    lat_rnd = 0;
    lat = 4;
    wait_ready("t4_start");
    p = int'(pc);
    pc_up = 1;
    step();
    pc_up = 1;
    step();
    pc_up = 0;
    mpc = (mpc + 2) % 128;
    chk("t4_state_drain", state_o, 2);
    chk("t4_pc", pc, (p + 2) % 128);
    chk("t4_old_addr", rom_addr, (p + 1) % 128);
    chk("t4_rom_rd", rom_rd, 1);
    hold_ir = ir;
    n = 0;
    while (state_o == 2 && n < 20) begin
      step();
      n++;
    end
    chk("t4_refetch_state", state_o, 0);
    chk("t4_refetch_addr", rom_addr, (p + 2) % 128);
    chk("t4_ir_kept", ir, hold_ir);
    chk("t4_stale_dropped", fetch_busy, 1);
    fetch();
    lat = 1;
    step();
    pc_clr = 1;
    step();
    pc_clr = 0;
    mpc = 0;
    chk("t5_clr_pc", pc, 0);
    chk("t5_clr_ir", ir, 0);
    chk("t5_clr_ir_valid", ir_valid, 0);
    repeat (5) fetch();
    wait_ready("t5_hold");
    chk("t5_pc5", pc, 5);
    chk("t5_state_hold", state_o, 1);
    pc_clr = 1;
    pc_up = 1;
    step();
    pc_clr = 0;
    pc_up = 0;
    mpc = 0;
    chk("t5_clrup_pc", pc, 0);
    chk("t5_clrup_ir", ir, 0);
    chk("t5_clrup_ir_valid", ir_valid, 0);
    chk("t5_clrup_state", state_o, 0);
    chk("t5_clrup_addr", rom_addr, 0);
    chk("t5_clrup_rd", rom_rd, 1);
    repeat (127) begin
      wait_ready("wrap_walk");
      pc_up = 1;
      step();
      pc_up = 0;
    end
    chk("wrap_pc7f", pc, 127);
    wait_ready("wrap_hold");
    pc_up = 1;
    step();
    pc_up = 0;
    chk("wrap_pc0", pc, 0);
    chk("wrap_addr0", rom_addr, 0);
    mpc = 0;
    fetch();
    lat = 4;
    step();
    chk("t6_mid_fetch", rom_rd, 1);
    reset = 0;
    #1;
    chk("t6_pc", pc, 0);
    chk("t6_ir", ir, 0);
    chk("t6_state", state_o, 0);
    chk("t6_rom_addr", rom_addr, 0);
    exp_q.delete();
    mpc = 0;
    step();
    step();
    reset = 1;
    step();
    chk("t6_addr_after", rom_addr, 0);
    fetch();
    repeat (3) step();
    chk("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies 16-bit instructions to the processor Controller FSM, acting as the responder to the controller's pc_clr / pc_up / ld requests.
- Owns the program counter and instruction register (IR).
- Prefetches the word at PC from instruction ROM over a req/ack handshake, so a controller ld normally completes in one cycle.
- Sits between the Controller and the instruction ROM.

Parameters:
AW, 7, PC / ROM address width in bits
DW, 16, instruction width in bits

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
pc_clr  in  1  controller: clear PC to 0, discard prefetch, clear IR
pc_up  in  1  controller: increment PC
ld  in  1  controller: load IR from prefetch buffer
ir  out  DW  instruction register, to controller instruction input
ir_valid  out  1  ir holds a word fetched since last reset/pc_clr
fetch_busy  out  1  high when ld cannot complete this cycle (prefetch not valid)
pc  out  AW  current program counter
rom_addr  out  AW  ROM address, registered, stable while rom_rd high
rom_rd  out  1  ROM read request, level, held until rom_ack
rom_data  in  DW  ROM read data, valid in the cycle rom_ack=1
rom_ack  in  1  ROM completion, one cycle per request, latency >=1 cycle
state_o  out  2  debug: FSM state (FETCH=0, HOLD=1, DRAIN=2)

Behaviour:
- Reset (reset=0, async):
  - pc=0, ir=0, ir_valid=0, rom_addr=0, rom_rd=1, prefetch buffer invalid, ld_pend=0.
  - state=FETCH, so prefetch of address 0 starts on the first cycle after release.
- FETCH:
  - rom_rd=1, rom_addr=pc.
  - On rom_ack, capture rom_data into the prefetch buffer, set pf_valid=1, and go to HOLD.
  - If ld_pend=1 at that ack, ir<=rom_data, ir_valid<=1 and ld_pend<=0 on the same edge.
- HOLD:
  - rom_rd=0, pf_valid=1.
  - On ld, ir<=buffer and ir_valid<=1 on the next edge.
- ld with pf_valid=0:
  - Sets ld_pend (fetch_busy=1 combinationally); ir is unchanged until the ack.
  - fetch_busy = ~pf_valid.
- pc_up:
  - pc <= pc+1 mod 2^AW (AW'h7F wraps to 0) and pf_valid<=0.
  - From HOLD: go to FETCH with rom_addr=new pc.
  - From FETCH with a request outstanding: go to DRAIN.
- pc_up and ld in the same cycle:
  - The IR gets the buffered word for the old pc.
  - The PC increments and the refetch starts the next cycle.
  - This is the normal controller fetch state.
- DRAIN:
  - rom_rd stays 1 with the old rom_addr until rom_ack.
  - The stale rom_data is dropped: no buffer or IR update, and any ld_pend stays pending.
  - Next state is FETCH with rom_addr=pc.
- pc_clr (priority over pc_up and ld):
  - pc<=0, ir<=0 (NOOP), ir_valid<=0, ld_pend<=0, pf_valid<=0.
  - From FETCH or DRAIN with a request outstanding: go to DRAIN.
  - From HOLD: go to FETCH at address 0.
- Repeated pc_up/pc_clr while in DRAIN: pc updates, and the state stays DRAIN until the single outstanding ack is absorbed.
- rom_rd never deasserts before rom_ack, and rom_addr never changes while rom_rd=1.
- rom_ack while rom_rd=0 is ignored.
- Reset mid-transaction:
  - All state clears immediately; an ack for the aborted request is not tracked.
  - The ROM model must be reset with the block.

Test Plan:
- Reset release, ROM latency 1, rom[0]=16'h20A1 -> rom_rd=1 with addr 0, ack, state_o=1. Then ld+pc_up -> next edge ir=16'h20A1, ir_valid=1, pc=1, rom_addr=1.
- Program 20A1, 21A2, 2033, 28A4, 4125, 3536, 4640, 10BB, 5000 at latency 1, one ld+pc_up every 4 cycles -> ir sequence matches exactly, pc ends at 9, fetch_busy=0 at every ld.
- ROM latency 3, ld+pc_up issued back-to-back -> second ld sees fetch_busy=1 and ld_pend; ir updates on the edge of the rom_ack for addr 1. No word is skipped or duplicated.
- pc_up during an outstanding fetch (latency 4) -> state_o=2, the stale ack is dropped (ir unchanged), then addr pc+1 is requested and delivered.
- pc_clr while in HOLD at pc=5, same cycle as pc_up -> pc=0, ir=0, ir_valid=0, refetch from addr 0. Preload pc=7'h7F then pc_up -> pc=0.
- Assert reset low mid-fetch with rom_rd=1 -> immediately pc=0, ir=0, state_o=0. After release, rom_addr=0 and the first ld yields rom[0].
